// File: rtl/apb_slave_regfile_pkg.sv
// Shared constants and types for the APB register-file completer.
package apb_pkg;

  localparam int unsigned APB_ADDR_W   = 5;
  localparam int unsigned APB_DATA_W   = 32;
  localparam logic [31:0] ID_VALUE_DEF = 32'hA9B0_0001;

  // Transfer FSM: IDLE waits for setup, ACCESS counts wait states, RESP drives PREADY.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between one master and the register-file completer.
interface apb_slave_regfile_if #(
  parameter int unsigned ADDR_W = apb_pkg::APB_ADDR_W,
  parameter int unsigned DATA_W = apb_pkg::APB_DATA_W
) ();

  logic              PSELx;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_slave_regfile_regbank.sv
// Register storage: NUM_REGS words cleared by reset, one write port and one
// combinational read port. Entry 0 is never written by the top (read-only ID).
module apb_regbank #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 28
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  // Clear all words on reset; otherwise write the addressed word when enabled.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (we_i && (waddr_i == ADDR_W'(i))) begin
          mem_q[i] <= wdata_i;
        end
      end
    end
  end

  // Read mux; indices beyond the implemented range return zero.
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (raddr_i == ADDR_W'(i)) begin
        rdata_o = mem_q[i];
      end else begin
        rdata_o = rdata_o;
      end
    end
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a register bank, programmable wait states and error
// response for out-of-range accesses and writes to the read-only ID word.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int unsigned       DATA_W      = APB_DATA_W,
  parameter int unsigned       ADDR_W      = APB_ADDR_W,
  parameter int unsigned       NUM_REGS    = 28,
  parameter int unsigned       WAIT_CYCLES = 2,
  parameter logic [DATA_W-1:0] ID_VALUE    = ID_VALUE_DEF
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb_slave_regfile_if.slave  apb
);

  // One extra bit so NUM_REGS = 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [3:0]      WAIT_LD    = 4'(WAIT_CYCLES);

  apb_state_e        state_q,   state_d;
  logic [3:0]        cnt_q,     cnt_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic              wr_q,      wr_d;
  logic              pready_q,  pready_d;
  logic              pslverr_q, pslverr_d;
  logic [DATA_W-1:0] prdata_q,  prdata_d;

  logic              we_s;
  logic              err_s;
  logic [DATA_W-1:0] bank_rdata_s;
  logic [DATA_W-1:0] rd_data_s;

  apb_regbank #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_regbank (
    .clk_i   (PCLK),
    .rst_n_i (PRESETn),
    .we_i    (we_s),
    .waddr_i (addr_q),
    .wdata_i (apb.PWDATA),
    .raddr_i (addr_q),
    .rdata_o (bank_rdata_s)
  );

  // Error decode and read-data select from the latched address and direction.
  always_comb begin
    err_s = ({1'b0, addr_q} >= NUM_REGS_L) || (wr_q && (addr_q == '0));
    if (addr_q == '0) begin
      rd_data_s = ID_VALUE;
    end else begin
      rd_data_s = bank_rdata_s;
    end
  end

  // Next-state, wait counter, commit strobe and registered-response values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    we_s      = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        // A setup phase is accepted from IDLE or directly in the RESP cycle.
        if (apb.PSELx && !apb.PENABLE) begin
          state_d = ACCESS;
          addr_d  = apb.PADDR;
          wr_d    = apb.PWRITE;
          cnt_d   = WAIT_LD;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (!apb.PSELx) begin
          state_d = IDLE;
        end else if (apb.PENABLE) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d   = RESP;
            pready_d  = 1'b1;
            pslverr_d = err_s;
            we_s      = wr_q && !err_s;
            if (!wr_q && !err_s) begin
              prdata_d = rd_data_s;
            end else begin
              prdata_d = '0;
            end
          end
        end else begin
          state_d = ACCESS;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and response registers; reset abandons any transfer in flight.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign apb.PREADY  = pready_q;
  assign apb.PSLVERR = pslverr_q;
  assign apb.PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench: bus 0 drives a WAIT_CYCLES=2 instance, bus 1 a zero-wait
// instance. Stimulus pushes expected responses; a negedge monitor pops them.
module tb_apb_slave_regfile;
  import apb_pkg::*;

  localparam int W0 = 2;
  localparam int W1 = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic        err;
    logic        is_rd;
    logic [31:0] rd;
  } exp_t;

  logic PCLK;
  logic PRESETn;
  int   cyc;
  int   vectors;
  int   miscompares;

  logic [1:0]  psel, pen, pwr;
  logic [4:0]  paddr  [2];
  logic [31:0] pwdata [2];
  logic [1:0]  prdy, pslv;
  logic [31:0] prd    [2];

  exp_t q0[$];
  exp_t q1[$];

  apb_slave_regfile_if #(.ADDR_W(5), .DATA_W(32)) if0 ();
  apb_slave_regfile_if #(.ADDR_W(5), .DATA_W(32)) if1 ();

  assign if0.PSELx   = psel[0];
  assign if0.PENABLE = pen[0];
  assign if0.PWRITE  = pwr[0];
  assign if0.PADDR   = paddr[0];
  assign if0.PWDATA  = pwdata[0];
  assign if1.PSELx   = psel[1];
  assign if1.PENABLE = pen[1];
  assign if1.PWRITE  = pwr[1];
  assign if1.PADDR   = paddr[1];
  assign if1.PWDATA  = pwdata[1];
  assign prdy = {if1.PREADY, if0.PREADY};
  assign pslv = {if1.PSLVERR, if0.PSLVERR};
  assign prd[0] = if0.PRDATA;
  assign prd[1] = if1.PRDATA;

  apb_slave_regfile #(.WAIT_CYCLES(W0)) u0 (.PCLK(PCLK), .PRESETn(PRESETn), .apb(if0));
  apb_slave_regfile #(.WAIT_CYCLES(W1)) u1 (.PCLK(PCLK), .PRESETn(PRESETn), .apb(if1));

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Cycle index: value seen at posedge+1 and at the following negedge.
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor for one bus: pop on PREADY, otherwise outputs must be quiet.
  task automatic mon(input int b);
    exp_t e;
    if (prdy[b]) begin
      if ((b == 0 && q0.size() == 0) || (b == 1 && q1.size() == 0)) begin
        chk($sformatf("b%0d unexpected PREADY", b), 32'd1, 32'd0);
      end else begin
        if (b == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("b%0d ready cycle", b), 32'(cyc), e.cyc);
        chk($sformatf("b%0d PSLVERR", b), {31'd0, pslv[b]}, {31'd0, e.err});
        if (e.is_rd) chk($sformatf("b%0d PRDATA", b), prd[b], e.rd);
      end
    end else if (pslv[b] || (prd[b] != 32'd0)) begin
      chk($sformatf("b%0d quiet outputs", b), {pslv[b], prd[b][30:0]}, 32'd0);
    end
  endtask

  always @(negedge PCLK) begin
    if (PRESETn) begin
      mon(0);
      mon(1);
    end
  end

  // One complete transfer; called at posedge+1 and returns at posedge+1 of
  // the RESP cycle with the bus idle, so an immediate next call is back-to-back.
  // Setup in cycle T0, PREADY expected in cycle T1+W+1 = T0+W+2.
  task automatic xfer(input int b, input logic wr, input logic [4:0] a, input logic [31:0] d,
                      input logic e_err, input logic [31:0] e_rd, input logic garble);
    exp_t e;
    logic done;
    e.cyc   = 32'(cyc + 2 + ((b == 0) ? W0 : W1));
    e.err   = e_err;
    e.is_rd = ~wr;
    e.rd    = e_rd;
    if (b == 0) q0.push_back(e);
    else        q1.push_back(e);
    psel[b] = 1'b1; pen[b] = 1'b0; pwr[b] = wr; paddr[b] = a; pwdata[b] = d;
    @(posedge PCLK); #1;
    pen[b] = 1'b1;
    if (garble) begin
      paddr[b] = ~a;
      pwr[b]   = ~wr;
    end
    done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(posedge PCLK); #1;
      if (prdy[b]) done = 1'b1;
    end
    if (!done) chk($sformatf("b%0d transfer timeout", b), 32'd0, 32'd1);
    psel[b] = 1'b0; pen[b] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge PCLK); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; vectors = 0; miscompares = 0;
    psel = 2'b00; pen = 2'b00; pwr = 2'b00;
    paddr[0] = 5'd0; paddr[1] = 5'd0; pwdata[0] = 32'd0; pwdata[1] = 32'd0;
    PRESETn = 1'b0;
    idle(3);
    chk("reset PREADY", {30'd0, prdy}, 32'd0);
    chk("reset PSLVERR", {30'd0, pslv}, 32'd0);
    chk("reset PRDATA0", prd[0], 32'd0);
    chk("reset PRDATA1", prd[1], 32'd0);
    PRESETn = 1'b1;
    idle(1);

    // Bus 0, two wait states.
    xfer(0, 1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 32'd0,          1'b0);
    xfer(0, 1'b0, 5'd5,  32'd0,         1'b0, 32'hDEAD_BEEF,  1'b0);
    xfer(0, 1'b1, 5'd0,  32'h0000_0001, 1'b1, 32'd0,          1'b0);
    xfer(0, 1'b0, 5'd0,  32'd0,         1'b0, 32'hA9B0_0001,  1'b0);
    xfer(0, 1'b0, 5'd30, 32'd0,         1'b1, 32'd0,          1'b0);
    xfer(0, 1'b1, 5'd31, 32'h0BAD_0BAD, 1'b1, 32'd0,          1'b0);
    xfer(0, 1'b0, 5'd27, 32'd0,         1'b0, 32'd0,          1'b0);
    xfer(0, 1'b1, 5'd27, 32'hCAFE_F00D, 1'b0, 32'd0,          1'b1);
    xfer(0, 1'b0, 5'd27, 32'd0,         1'b0, 32'hCAFE_F00D,  1'b0);
    xfer(0, 1'b0, 5'd28, 32'd0,         1'b1, 32'd0,          1'b0);
    xfer(0, 1'b0, 5'd4,  32'd0,         1'b0, 32'd0,          1'b1);
    idle(2);

    // Abort: write idx 7 dropped after one wait cycle.
    psel[0] = 1'b1; pen[0] = 1'b0; pwr[0] = 1'b1; paddr[0] = 5'd7; pwdata[0] = 32'h55;
    idle(1);
    pen[0] = 1'b1;
    idle(1);
    psel[0] = 1'b0; pen[0] = 1'b0;
    idle(5);
    xfer(0, 1'b0, 5'd7, 32'd0, 1'b0, 32'd0, 1'b0);

    // PENABLE without setup is ignored.
    psel[0] = 1'b1; pen[0] = 1'b1; paddr[0] = 5'd1;
    idle(4);
    chk("no-setup state", {30'd0, u0.state_q}, {30'd0, IDLE});
    psel[0] = 1'b0; pen[0] = 1'b0;
    idle(1);

    // Back-to-back: setup of the read in the RESP cycle of the write.
    xfer(0, 1'b1, 5'd3, 32'h0000_1234, 1'b0, 32'd0,         1'b0);
    xfer(0, 1'b0, 5'd3, 32'd0,         1'b0, 32'h0000_1234, 1'b0);
    idle(2);

    // Bus 1, zero wait states.
    xfer(1, 1'b0, 5'd0,  32'd0,         1'b0, 32'hA9B0_0001, 1'b0);
    xfer(1, 1'b1, 5'd2,  32'hA5A5_5A5A, 1'b0, 32'd0,         1'b0);
    xfer(1, 1'b0, 5'd2,  32'd0,         1'b0, 32'hA5A5_5A5A, 1'b0);
    xfer(1, 1'b0, 5'd30, 32'd0,         1'b1, 32'd0,         1'b0);
    idle(2);

    // Reset in the middle of a bus-0 write access phase.
    psel[0] = 1'b1; pen[0] = 1'b0; pwr[0] = 1'b1; paddr[0] = 5'd5; pwdata[0] = 32'h1111_1111;
    idle(1);
    pen[0] = 1'b1;
    idle(1);
    PRESETn = 1'b0;
    #1;
    chk("mid-reset PREADY", {31'd0, prdy[0]}, 32'd0);
    chk("mid-reset state", {30'd0, u0.state_q}, {30'd0, IDLE});
    psel[0] = 1'b0; pen[0] = 1'b0;
    idle(2);
    PRESETn = 1'b1;
    idle(1);
    xfer(0, 1'b0, 5'd5, 32'd0, 1'b0, 32'd0, 1'b0);
    xfer(1, 1'b0, 5'd2, 32'd0, 1'b0, 32'd0, 1'b0);
    idle(3);

    chk("b0 pending responses", 32'(q0.size()), 32'd0);
    chk("b1 pending responses", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
